// File: rtl/lbdr_route_unit.sv
// LBDR route-computation unit for one router input port: minimal 5-port routing,
// allocator handshake, per-packet port hold and drop of unroutable packets. Optional deroute: LBDR_DEROUTE_EN.
module lbdr_route_unit #(
    parameter int ADDR_W  = 4,
    parameter int IN_PORT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        Rxy_rst,
    input  logic [3:0]        Cx_rst,
    input  logic [ADDR_W-1:0] cur_addr_rst,
    input  logic [1:0]        dr_rst,
    input  logic              flit_valid,
    input  logic [2:0]        flit_type,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              flit_pop,
    output logic [4:0]        route_req,
    input  logic [4:0]        route_grant,
    output logic [4:0]        route_sel,
    output logic              route_busy,
    output logic              route_err,
    output logic              drop
);
    localparam int HW = ADDR_W / 2;
    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] TAIL   = 3'b100;
`ifdef LBDR_DEROUTE_EN
    localparam logic DEROUTE_EN = 1'b1;
`else
    localparam logic DEROUTE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DROP} state_t;

    state_t            state_reg;
    logic [7:0]        rxy_reg;
    logic [3:0]        cx_reg;
    logic [ADDR_W-1:0] cur_reg;
    logic [1:0]        dr_reg;

    logic [HW-1:0]        x_cur, x_dst;
    logic [ADDR_W-HW-1:0] y_cur, y_dst;
    logic n1, e1, w1, s1, l_hit;
    logic [3:0] min_raw, min_masked, dr_vec;
    logic       dr_ok;
    logic [4:0] cand;
    logic       hdr_in, tail_pop, grant_ok;

    assign x_cur = cur_reg[HW-1:0];
    assign y_cur = cur_reg[ADDR_W-1:HW];
    assign x_dst = dst_addr[HW-1:0];
    assign y_dst = dst_addr[ADDR_W-1:HW];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;
    assign l_hit = ~(n1 | e1 | w1 | s1);

    // Rxy bit map: {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
    assign min_raw[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_reg[0]) | (n1 & w1 & rxy_reg[1])) & cx_reg[0];
    assign min_raw[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_reg[2]) | (e1 & s1 & rxy_reg[3])) & cx_reg[1];
    assign min_raw[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_reg[4]) | (w1 & s1 & rxy_reg[5])) & cx_reg[2];
    assign min_raw[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_reg[6]) | (s1 & w1 & rxy_reg[7])) & cx_reg[3];

    // No U-turn: the output facing the input port is never a candidate.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign min_masked[gi] = (IN_PORT == gi) ? 1'b0 : min_raw[gi];
            assign dr_vec[gi]     = (dr_reg == gi[1:0]);
        end
    endgenerate

    assign dr_ok = DEROUTE_EN & cx_reg[dr_reg] & (int'(dr_reg) != IN_PORT);

    always_comb begin
        cand = 5'b0;
        if (l_hit)
            cand = 5'b10000;
        else if (|min_masked)
            cand = {1'b0, min_masked};
        else if (dr_ok)
            cand = {1'b0, dr_vec};
    end

    assign hdr_in   = flit_valid & (flit_type == HEADER);
    assign tail_pop = flit_valid & flit_pop & (flit_type == TAIL);
    assign grant_ok = (route_grant != 5'b0) & ((route_grant & (route_grant - 5'd1)) == 5'b0)
                    & ((route_grant & ~route_req) == 5'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxy_reg   <= Rxy_rst;
            cx_reg    <= Cx_rst;
            cur_reg   <= cur_addr_rst;
            dr_reg    <= dr_rst;
            state_reg <= IDLE;
            route_req <= 5'b0;
            route_sel <= 5'b0;
            route_err <= 1'b0;
            drop      <= 1'b0;
        end else begin
            route_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hdr_in) begin
                        if (cand != 5'b0) begin
                            route_req <= cand;
                            state_reg <= REQ;
                        end else begin
                            route_err <= 1'b1;
                            drop      <= 1'b1;
                            state_reg <= DROP;
                        end
                    end
                end
                REQ: begin
                    if (grant_ok) begin
                        route_sel <= route_grant;
                        route_req <= 5'b0;
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tail_pop) begin
                        route_sel <= 5'b0;
                        state_reg <= IDLE;
                    end
                end
                DROP: begin
                    if (tail_pop) begin
                        drop      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign route_busy = (state_reg == REQ) | (state_reg == ACTIVE);

endmodule
